// File: rtl/acp_fifo_wr_arb_pkg.sv
// Shared constants and types for the two-requester FIFO write arbiter.
package acp_fifo_wr_arb_pkg;

    localparam int unsigned C_WIDTH = 256;  // shared FIFO data width
    localparam int unsigned C_DEPTH = 16;   // FIFO word capacity
    localparam int unsigned LEVEL_W = 5;    // holds 0..C_DEPTH inclusive

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/acp_fifo_level.sv
// Tracks FIFO occupancy from the write strobe and the consumer's effective reads.
module acp_fifo_level
    import acp_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned C_DEPTH = acp_fifo_wr_arb_pkg::C_DEPTH
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               wren,
    input  logic               rden,
    input  logic               empty,
    output logic [LEVEL_W-1:0] level,
    output logic               full
);

    logic rd_eff;
    logic inc;
    logic dec;

    // A read on an empty FIFO moves nothing; a simultaneous read and write cancel out
    always_comb begin
        rd_eff = rden & ~empty;
        inc    = wren & ~rd_eff;
        dec    = rd_eff & ~wren;
    end

    // Occupancy counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            level <= '0;
        end else if (inc) begin
            level <= level + 1'b1;
        end else if (dec) begin
            level <= level - 1'b1;
        end
    end

    assign full = (level == LEVEL_W'(C_DEPTH));

    // Space is reserved at grant, so either of these means the reservation or the consumer broke
    a_no_overflow:  assert property (@(posedge sys_clk) disable iff (sys_rst) !(inc && full));
    a_no_underflow: assert property (@(posedge sys_clk) disable iff (sys_rst) !(dec && level == '0));

endmodule

// File: rtl/acp_fifo_wr_arb.sv
// Round-robin burst arbiter feeding two requesters into one shared write FIFO.
module acp_fifo_wr_arb
    import acp_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned C_WIDTH = acp_fifo_wr_arb_pkg::C_WIDTH,
    parameter int unsigned C_DEPTH = acp_fifo_wr_arb_pkg::C_DEPTH
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               s0_req,
    input  logic [3:0]         s0_len,
    output logic               s0_gnt,
    input  logic [C_WIDTH-1:0] s0_wdata,
    input  logic               s0_wvalid,
    output logic               s0_wready,
    input  logic               s1_req,
    input  logic [3:0]         s1_len,
    output logic               s1_gnt,
    input  logic [C_WIDTH-1:0] s1_wdata,
    input  logic               s1_wvalid,
    output logic               s1_wready,
    output logic [C_WIDTH-1:0] fifo_wdata,
    output logic               fifo_wren,
    input  logic               fifo_rden,
    input  logic               fifo_empty,
    output logic [LEVEL_W-1:0] level,
    output logic               full
);

    localparam logic [LEVEL_W:0] DEPTH_V = (LEVEL_W + 1)'(C_DEPTH);

    arb_state_t     state_q;
    logic [1:0]     gnt_q;     // one-hot, bit n = requester n
    logic           rr_q;      // requester with priority for the next grant
    logic [3:0]     cnt_q;     // beats left minus one
    logic           armed_q;   // holds off grants until the second edge after reset

    logic [1:0]     req_v;
    logic           sel;
    logic [3:0]     sel_len;
    logic [LEVEL_W:0] need;
    logic [LEVEL_W:0] space;
    logic           eligible;

    // Pick the considered requester; rr has strict priority even when it cannot fit
    always_comb begin
        req_v    = {s1_req, s0_req};
        sel      = req_v[rr_q] ? rr_q : ~rr_q;
        sel_len  = sel ? s1_len : s0_len;
        need     = {2'b00, sel_len} + 1'b1;
        space    = DEPTH_V - {1'b0, level};
        eligible = req_v[sel] && (need <= space);
    end

    // Arbiter FSM: grant in IDLE, count accepted beats in BURST
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (armed_q && eligible) begin
                        state_q <= BURST;
                        gnt_q   <= sel ? 2'b10 : 2'b01;
                        cnt_q   <= sel_len;
                    end
                end
                BURST: begin
                    if (fifo_wren) begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            rr_q    <= ~gnt_q[1];
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s0_gnt    = gnt_q[0];
    assign s1_gnt    = gnt_q[1];
    assign s0_wready = gnt_q[0];
    assign s1_wready = gnt_q[1];
    assign fifo_wren = (s0_wvalid & gnt_q[0]) | (s1_wvalid & gnt_q[1]);

    // Zero-latency data mux steered by the grant
    always_comb begin
        fifo_wdata = '0;
        if (gnt_q[0]) begin
            fifo_wdata = s0_wdata;
        end else if (gnt_q[1]) begin
            fifo_wdata = s1_wdata;
        end
    end

    acp_fifo_level #(
        .C_DEPTH (C_DEPTH)
    ) u_level (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wren    (fifo_wren),
        .rden    (fifo_rden),
        .empty   (fifo_empty),
        .level   (level),
        .full    (full)
    );

endmodule

// File: tb/tb_acp_fifo_wr_arb.sv
// Self-checking bench for acp_fifo_wr_arb: directed scenarios plus randomized traffic
// compared against a burst-level reference model.
module tb_acp_fifo_wr_arb;

    localparam int W     = 256;
    localparam int DEPTH = 16;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [1:0]   req;
    logic [1:0]   wvalid;
    logic [3:0]   len [2];
    logic [W-1:0] wdata [2];
    logic         rden;
    logic         fifo_empty;

    logic         s0_gnt, s1_gnt, s0_wready, s1_wready, fifo_wren, full;
    logic [W-1:0] fifo_wdata;
    logic [4:0]   level;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the FIFO, how many beats remain, occupancy, priority
    int m_level, m_owner, m_left, m_rr;
    bit m_armed;

    always #5 sys_clk = ~sys_clk;

    acp_fifo_wr_arb #(
        .C_WIDTH (W),
        .C_DEPTH (DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .s0_req     (req[0]),
        .s0_len     (len[0]),
        .s0_gnt     (s0_gnt),
        .s0_wdata   (wdata[0]),
        .s0_wvalid  (wvalid[0]),
        .s0_wready  (s0_wready),
        .s1_req     (req[1]),
        .s1_len     (len[1]),
        .s1_gnt     (s1_gnt),
        .s1_wdata   (wdata[1]),
        .s1_wvalid  (wvalid[1]),
        .s1_wready  (s1_wready),
        .fifo_wdata (fifo_wdata),
        .fifo_wren  (fifo_wren),
        .fifo_rden  (rden),
        .fifo_empty (fifo_empty),
        .level      (level),
        .full       (full)
    );

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit exp_wren();
        return (m_owner >= 0) ? bit'(wvalid[m_owner]) : 1'b0;
    endfunction

    task automatic model_reset();
        m_level = 0; m_owner = -1; m_left = 0; m_rr = 0; m_armed = 0;
    endtask

    // Apply one clock edge's worth of rules to the model using the current inputs
    task automatic model_tick();
        int lvl0 = m_level;
        bit wr   = exp_wren();
        bit rd   = rden && !fifo_empty;
        if (wr && !rd) m_level++;
        else if (rd && !wr) m_level--;
        if (m_owner >= 0) begin
            if (wr) begin
                m_left--;
                if (m_left == 0) begin
                    m_rr    = 1 - m_owner;
                    m_owner = -1;
                end
            end
        end else if (m_armed) begin
            int c = req[m_rr] ? m_rr : 1 - m_rr;
            if (req[c] && int'(len[c]) + 1 <= DEPTH - lvl0) begin
                m_owner = c;
                m_left  = int'(len[c]) + 1;
            end
        end
        m_armed = 1;
    endtask

    task automatic adv();
        model_tick();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; req = '0; wvalid = '0; rden = 1'b0; fifo_empty = 1'b1;
        len[0] = '0; len[1] = '0;
        @(negedge sys_clk);
        model_reset();
        sys_rst = 1'b0;
        adv();
    endtask

    // Hold req until the DUT grants, then run until that grant drops (bounded)
    task automatic wait_burst(input int n);
        bit seen = 0;
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (n == 1 ? s1_gnt : s0_gnt) begin
                seen = 1; req[n] = 1'b0;
            end else if (seen) begin
                done = 1;
            end
            if (!done) adv();
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL burst_timeout: requester %0d burst seen=%0d done=0, required done=1", n, seen);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; req = 2'b01; len[0] = 4'd0; wvalid = 2'b01; wdata[0] = rand_word();
        rden = 1'b1; fifo_empty = 1'b0;
        repeat (2) @(negedge sys_clk);
        #1;
        n_tests++; if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rst_gnt: got %b%b required 00", s1_gnt, s0_gnt); end
        n_tests++; if (s0_wready !== 1'b0 || s1_wready !== 1'b0) begin
            n_fail++; $display("FAIL rst_wready: got %b%b required 00", s1_wready, s0_wready); end
        n_tests++; if (fifo_wren !== 1'b0) begin
            n_fail++; $display("FAIL rst_wren: got %b required 0", fifo_wren); end
        n_tests++; if (fifo_wdata !== '0) begin
            n_fail++; $display("FAIL rst_wdata: got %h required 0", fifo_wdata); end
        n_tests++; if (level !== 5'd0 || full !== 1'b0) begin
            n_fail++; $display("FAIL rst_level: got level=%0d full=%b required 0/0", level, full); end
        model_reset();
        rden = 1'b0; fifo_empty = 1'b1; sys_rst = 1'b0;
        adv();
        #1;
        n_tests++; if (s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rst_first_edge_gnt: got %b required 0", s0_gnt); end
        adv();
        #1;
        n_tests++; if (s0_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rst_second_edge_gnt: got %b required 1", s0_gnt); end
        req[0] = 1'b0;
        adv();
        #1;
        n_tests++; if (level !== 5'd1 || s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rst_one_beat: got level=%0d gnt=%b required 1/0", level, s0_gnt); end
    endtask

    task automatic test_single_burst();
        int wr_cnt = 0;
        do_reset();
        req[0] = 1'b1; len[0] = 4'd3; wvalid[0] = 1'b1;
        #1;
        n_tests++; if (s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_gnt: got %b required 0", s0_gnt); end
        adv();
        #1;
        n_tests++; if (s0_gnt !== 1'b1) begin
            n_fail++; $display("FAIL single_gnt_latency: got %b required 1", s0_gnt); end
        req[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wdata[0] = rand_word();
            #1;
            if (fifo_wren === 1'b1) begin
                wr_cnt++;
                n_tests++; if (fifo_wdata !== wdata[0]) begin
                    n_fail++; $display("FAIL single_wdata: got %h required %h", fifo_wdata, wdata[0]); end
            end
            adv();
        end
        #1;
        n_tests++; if (wr_cnt != 4) begin
            n_fail++; $display("FAIL single_wren_count: got %0d required 4", wr_cnt); end
        n_tests++; if (level !== 5'd4 || s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL single_end: got level=%0d gnt=%b required 4/0", level, s0_gnt); end
        // rr must now favour requester 1
        req = 2'b11; len[0] = 4'd0; len[1] = 4'd0; wvalid = '0;
        adv();
        #1;
        n_tests++; if (s1_gnt !== 1'b1 || s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL single_rr_next: got gnt=%b%b required 10", s1_gnt, s0_gnt); end
    endtask

    task automatic test_round_robin();
        int exp_own [10];
        int own;
        exp_own = '{-1, 0, 0, -1, 1, 1, -1, 0, 0, -1};
        do_reset();
        req = 2'b11; len[0] = 4'd1; len[1] = 4'd1; wvalid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) req = '0;
            #1;
            own = (s0_gnt && s1_gnt) ? 2 : s0_gnt ? 0 : s1_gnt ? 1 : -1;
            n_tests++; if (own != exp_own[i]) begin
                n_fail++; $display("FAIL rr_order cycle %0d: got owner %0d required %0d", i, own, exp_own[i]); end
            adv();
        end
        #1;
        n_tests++; if (level !== 5'd6) begin
            n_fail++; $display("FAIL rr_level: got %0d required 6", level); end
    endtask

    task automatic test_space_block();
        do_reset();
        req[1] = 1'b1; len[1] = 4'd13; wvalid[1] = 1'b1;
        wait_burst(1);
        wvalid = '0;
        n_tests++; if (level !== 5'd14) begin
            n_fail++; $display("FAIL space_prefill: got %0d required 14", level); end
        req = 2'b11; len[0] = 4'd3; len[1] = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (i >= 4) begin rden = 1'b1; fifo_empty = 1'b0; end
            #1;
            n_tests++; if (s0_gnt !== 1'b0 || s1_gnt !== 1'b0) begin
                n_fail++; $display("FAIL space_no_bypass cycle %0d: got gnt=%b%b required 00", i, s1_gnt, s0_gnt); end
            adv();
        end
        rden = 1'b0; fifo_empty = 1'b1;
        #1;
        n_tests++; if (level !== 5'd12 || s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL space_after_reads: got level=%0d gnt=%b required 12/0", level, s0_gnt); end
        adv();
        #1;
        n_tests++; if (s0_gnt !== 1'b1 || s1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL space_grant: got gnt=%b%b required 01", s1_gnt, s0_gnt); end
        req[0] = 1'b0; wvalid[0] = 1'b1;
        repeat (4) adv();
        wvalid = '0;
        #1;
        n_tests++; if (level !== 5'd16 || full !== 1'b1 || s1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL space_full_block: got level=%0d full=%b gnt1=%b required 16/1/0", level, full, s1_gnt); end
    endtask

    task automatic test_full_boundary();
        do_reset();
        req[1] = 1'b1; len[1] = 4'd15; wvalid[1] = 1'b1;
        wait_burst(1);
        wvalid = '0;
        n_tests++; if (level !== 5'd16 || full !== 1'b1) begin
            n_fail++; $display("FAIL full_fill: got level=%0d full=%b required 16/1", level, full); end
        req[0] = 1'b1; len[0] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (s0_gnt !== 1'b0) begin
                n_fail++; $display("FAIL full_no_gnt cycle %0d: got %b required 0", i, s0_gnt); end
            adv();
        end
        rden = 1'b1; fifo_empty = 1'b0;
        adv();
        rden = 1'b0; fifo_empty = 1'b1;
        #1;
        n_tests++; if (level !== 5'd15 || full !== 1'b0 || s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL full_after_read: got level=%0d full=%b gnt=%b required 15/0/0", level, full, s0_gnt); end
        adv();
        #1;
        n_tests++; if (s0_gnt !== 1'b1) begin
            n_fail++; $display("FAIL full_grant: got %b required 1", s0_gnt); end
        req[0] = 1'b0; wvalid[0] = 1'b1;
        adv();
        wvalid = '0;
        #1;
        n_tests++; if (level !== 5'd16) begin
            n_fail++; $display("FAIL full_refill: got %0d required 16", level); end
    endtask

    task automatic test_simul_rw();
        do_reset();
        req[0] = 1'b1; len[0] = 4'd2; wvalid[0] = 1'b1;
        wait_burst(0);
        wvalid = '0;
        req[1] = 1'b1; len[1] = 4'd7; wvalid[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rden = (m_owner == 1); fifo_empty = 1'b0;
            if (m_owner == 1) req[1] = 1'b0;
            #1;
            n_tests++; if (level !== 5'd3) begin
                n_fail++; $display("FAIL rw_level cycle %0d: got %0d required 3", i, level); end
            adv();
        end
        wvalid = '0; rden = 1'b1; fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adv();
            #1;
            n_tests++; if (level !== 5'd3) begin
                n_fail++; $display("FAIL rw_empty_read cycle %0d: got %0d required 3", i, level); end
        end
        rden = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req[0] = 1'b1; len[0] = 4'd7; wvalid[0] = 1'b1;
        adv();
        #1;
        n_tests++; if (s0_gnt !== 1'b1) begin
            n_fail++; $display("FAIL midrst_gnt: got %b required 1", s0_gnt); end
        req[0] = 1'b0;
        adv();
        adv();
        #1;
        n_tests++; if (level !== 5'd2) begin
            n_fail++; $display("FAIL midrst_two_beats: got %0d required 2", level); end
        #1 sys_rst = 1'b1;
        #1;
        n_tests++; if (s0_gnt !== 1'b0 || s0_wready !== 1'b0 || fifo_wren !== 1'b0) begin
            n_fail++; $display("FAIL midrst_drop: got gnt=%b wready=%b wren=%b required 0/0/0", s0_gnt, s0_wready, fifo_wren); end
        n_tests++; if (level !== 5'd0) begin
            n_fail++; $display("FAIL midrst_level: got %0d required 0", level); end
        model_reset();
        @(negedge sys_clk);
        wvalid = '0; req = 2'b10; len[1] = 4'd0; sys_rst = 1'b0;
        adv();
        #1;
        n_tests++; if (s1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL midrst_early_gnt: got %b required 0", s1_gnt); end
        adv();
        #1;
        n_tests++; if (s1_gnt !== 1'b1 || s0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL midrst_fresh_gnt: got gnt=%b%b required 10", s1_gnt, s0_gnt); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_data;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (req[n] && m_owner == n) begin
                    req[n] = 1'b0;
                end else if (!req[n] && m_owner != n && $urandom_range(3) == 0) begin
                    req[n] = 1'b1; len[n] = 4'($urandom_range(15));
                end
                wvalid[n] = ($urandom_range(9) < 7);
                wdata[n]  = rand_word();
            end
            rden = 1'($urandom_range(1)); fifo_empty = (m_level == 0);
            exp_data = (m_owner >= 0) ? wdata[m_owner] : '0;
            #1;
            n_tests++; if (s0_gnt !== (m_owner == 0) || s1_gnt !== (m_owner == 1)) begin
                n_fail++; $display("FAIL rand_gnt cycle %0d: got %b%b required owner %0d", i, s1_gnt, s0_gnt, m_owner); end
            n_tests++; if (s0_wready !== (m_owner == 0) || s1_wready !== (m_owner == 1)) begin
                n_fail++; $display("FAIL rand_wready cycle %0d: got %b%b required owner %0d", i, s1_wready, s0_wready, m_owner); end
            n_tests++; if (fifo_wren !== exp_wren()) begin
                n_fail++; $display("FAIL rand_wren cycle %0d: got %b required %b", i, fifo_wren, exp_wren()); end
            n_tests++; if (fifo_wdata !== exp_data) begin
                n_fail++; $display("FAIL rand_wdata cycle %0d: got %h required %h", i, fifo_wdata, exp_data); end
            n_tests++; if (int'(level) != m_level || full !== (m_level == DEPTH)) begin
                n_fail++; $display("FAIL rand_level cycle %0d: got %0d/%b required %0d", i, level, full, m_level); end
            adv();
        end
    endtask

    initial begin
        req = '0; wvalid = '0; len[0] = '0; len[1] = '0;
        wdata[0] = '0; wdata[1] = '0; rden = 1'b0; fifo_empty = 1'b1;
        model_reset();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_space_block();
        test_full_boundary();
        test_simul_rw();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
